// File: rtl/rr_regbank_arbiter_if.sv
// Bus bundle between the requester muxes and rr_regbank_arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface rr_regbank_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 4,
  parameter int TAG_W     = 2
);
  // Handshake: req[i] is a level request that the requester holds until it is
  // served; gnt and bus_valid mark the single word accepted in a cycle (there is
  // no back-pressure), and out_valid/out_tag mark that word two cycles later.
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] data_in;
  logic [NUM_REQ-1:0]           gnt;
  logic [WORD_SIZE-1:0]         bus_data;
  logic                         bus_valid;
  logic [TAG_W-1:0]             bus_tag;
  logic                         out_valid;
  logic [TAG_W-1:0]             out_tag;
  logic [TAG_W-1:0]             dbg_ptr;

`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]           lock;

  modport master (
    output req, data_in, lock,
    input  gnt, bus_data, bus_valid, bus_tag, out_valid, out_tag, dbg_ptr
  );
  modport slave (
    input  req, data_in, lock,
    output gnt, bus_data, bus_valid, bus_tag, out_valid, out_tag, dbg_ptr
  );
`else
  modport master (
    output req, data_in,
    input  gnt, bus_data, bus_valid, bus_tag, out_valid, out_tag, dbg_ptr
  );
  modport slave (
    input  req, data_in,
    output gnt, bus_data, bus_valid, bus_tag, out_valid, out_tag, dbg_ptr
  );
`endif
endinterface

// File: rtl/rr_regbank_arbiter.sv
// Round-robin arbiter feeding one shared two-stage register, tracking valid/tag
// alongside it. Optional burst locking is enabled by defining ARB_LOCK_EN.
module rr_regbank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 4,
  parameter int TAG_W     = 2,
  parameter int LOCK_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_regbank_arbiter_if.slave   bus
);

  localparam int SUM_W = TAG_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rr_regbank_arbiter: NUM_REQ must be 2..8");
  end
  if (TAG_W != $clog2(NUM_REQ)) begin : g_bad_tag_w
    $error("rr_regbank_arbiter: TAG_W must equal clog2(NUM_REQ)");
  end
  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("rr_regbank_arbiter: LOCK_MAX must be at least 1");
  end

  logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
  logic [WORD_SIZE-1:0] bus_data_q,  bus_data_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [TAG_W-1:0]     bus_tag_q,   bus_tag_d;
  logic [TAG_W-1:0]     ptr_q,       ptr_d;
  logic                 v_d1_q,      v_d1_d;
  logic [TAG_W-1:0]     t_d1_q,      t_d1_d;
  logic                 out_valid_q, out_valid_d;
  logic [TAG_W-1:0]     out_tag_q,   out_tag_d;

  // Rotating scan: candidate index is (ptr + k) mod NUM_REQ, first hit wins.
  logic [SUM_W-1:0] cand;
  logic             rr_found;
  logic [TAG_W-1:0] rr_win;
  logic [TAG_W-1:0] rr_next_ptr;

  always_comb begin
    cand     = '0;
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!rr_found && bus.req[cand[TAG_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = cand[TAG_W-1:0];
      end
    end
    rr_next_ptr = (rr_win == TAG_W'(NUM_REQ - 1)) ? '0 : rr_win + TAG_W'(1);
  end

`ifdef ARB_LOCK_EN
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              hold;

  // The holder is whoever owns gnt now; bus_tag_q names it while gnt is non-zero.
  always_comb begin
    hold = (gnt_q != '0) && bus.req[bus_tag_q] && bus.lock[bus_tag_q] &&
           (lock_cnt_q < LCNT_W'(LOCK_MAX - 1));
  end
`endif

  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;

  always_comb begin
    grant_any = rr_found;
    grant_idx = rr_win;
    ptr_d     = rr_found ? rr_next_ptr : ptr_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = '0;
    if (hold) begin
      grant_any  = 1'b1;
      grant_idx  = bus_tag_q;
      ptr_d      = ptr_q;
      lock_cnt_d = lock_cnt_q + LCNT_W'(1);
    end
`endif
    gnt_d       = '0;
    bus_data_d  = bus_data_q;
    bus_valid_d = 1'b0;
    bus_tag_d   = bus_tag_q;
    if (grant_any) begin
      gnt_d[grant_idx] = 1'b1;
      bus_data_d       = bus.data_in[grant_idx*WORD_SIZE +: WORD_SIZE];
      bus_valid_d      = 1'b1;
      bus_tag_d        = grant_idx;
    end
  end

  // Valid/tag ride alongside the shared register's mem and out stages.
  always_comb begin
    v_d1_d      = bus_valid_q;
    t_d1_d      = bus_tag_q;
    out_valid_d = v_d1_q;
    out_tag_d   = t_d1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_tag_q   <= '0;
      ptr_q       <= '0;
      v_d1_q      <= 1'b0;
      t_d1_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      bus_tag_q   <= bus_tag_d;
      ptr_q       <= ptr_d;
      v_d1_q      <= v_d1_d;
      t_d1_q      <= t_d1_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bus_data  = bus_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_tag   = bus_tag_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_regbank_arbiter.sv
// Bench for rr_regbank_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based arbitration model. Lock scenarios compile with ARB_LOCK_EN.
module tb_rr_regbank_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TW = 2;
  localparam int LM = 4;
  localparam int DW = N * W;
  localparam int VW = N + 1 + TW + W + 1 + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_regbank_arbiter_if #(.NUM_REQ(N), .WORD_SIZE(W), .TAG_W(TW)) bif ();

  rr_regbank_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .TAG_W(TW), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

`ifdef ARB_LOCK_EN
  logic [N-1:0] lock_in = '0;
`endif

  // ---------------- reference model ----------------
  int              m_ptr, m_holder, m_burst;
  logic [N-1:0]    m_gnt;
  logic            m_bus_valid;
  logic [TW-1:0]   m_bus_tag;
  logic [W-1:0]    m_bus_data;
  logic            m_out_valid;
  logic [TW-1:0]   m_out_tag;
  logic [TW:0]     exp_q[$];

  task automatic model_reset();
    m_ptr = 0; m_holder = -1; m_burst = 0;
    m_gnt = '0; m_bus_valid = 1'b0; m_bus_tag = '0; m_bus_data = '0;
    m_out_valid = 1'b0; m_out_tag = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [DW-1:0] d);
    int w;
    logic [TW:0] o;
    w = -1;
`ifdef ARB_LOCK_EN
    if (m_holder >= 0 && r[m_holder] && lock_in[m_holder] && m_burst < LM) begin
      w = m_holder;
      m_burst++;
    end
`endif
    if (w < 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_ptr   = (w + 1) % N;
        m_burst = 1;
      end
    end
    m_holder = w;
    if (w >= 0) begin
      m_gnt       = N'(1) << w;
      m_bus_valid = 1'b1;
      m_bus_tag   = TW'(w);
      m_bus_data  = d[w*W +: W];
    end else begin
      m_gnt       = '0;
      m_bus_valid = 1'b0;
    end
    exp_q.push_back({m_bus_valid, m_bus_tag});
    o = exp_q.pop_front();
    m_out_valid = o[TW];
    m_out_tag   = o[TW-1:0];
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_gnt, m_bus_valid, m_bus_tag, m_bus_data, m_out_valid, m_out_tag};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bif.gnt, bif.bus_valid, bif.bus_tag, bif.bus_data, bif.out_valid, bif.out_tag};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r, input logic [DW-1:0] d, input logic rst);
    bif.req     = r;
    bif.data_in = d;
`ifdef ARB_LOCK_EN
    bif.lock    = lock_in;
`endif
    reset       = rst;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_step(r, d);
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    n_checks++;
    if (obs_vec() !== '0 || bif.dbg_ptr !== '0)
      $display("FAIL reset_state cyc=%0d got=%h ptr=%0d exp=0 ptr=0", cyc, obs_vec(), bif.dbg_ptr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step('0, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== '0 || bif.dbg_ptr !== '0)
        $display("FAIL idle cyc=%0d got=%h ptr=%0d exp=0 ptr=0", cyc, obs_vec(), bif.dbg_ptr);
      else n_pass++;
    end
  endtask

  task automatic test_all_req();
    logic [DW-1:0] d;
    d = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, d, 1'b0);
      n_checks++;
      if (bif.bus_tag !== TW'(i % N) || bif.bus_data !== W'(i % N + 1) || bif.bus_valid !== 1'b1)
        $display("FAIL all_req_seq cyc=%0d got tag=%0d data=%h exp tag=%0d data=%h",
                 cyc, bif.bus_tag, bif.bus_data, i % N, i % N + 1);
      else n_pass++;
      n_checks++;
      if (i >= 2 && (bif.out_valid !== 1'b1 || bif.out_tag !== TW'((i - 2) % N)))
        $display("FAIL all_req_out cyc=%0d got v=%b tag=%0d exp v=1 tag=%0d",
                 cyc, bif.out_valid, bif.out_tag, (i - 2) % N);
      else if (obs_vec() !== exp_vec())
        $display("FAIL all_req_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    step('0, '0, 1'b1);
    step(4'b1000, 16'h4321, 1'b0);
    n_checks++;
    if (bif.gnt !== 4'b1000 || bif.bus_tag !== 2'd3 || bif.dbg_ptr !== 2'd0)
      $display("FAIL wrap_first cyc=%0d got gnt=%b tag=%0d ptr=%0d exp gnt=1000 tag=3 ptr=0",
               cyc, bif.gnt, bif.bus_tag, bif.dbg_ptr);
    else n_pass++;
    step(4'b1001, 16'h4321, 1'b0);
    n_checks++;
    if (bif.gnt !== 4'b0001 || bif.bus_tag !== 2'd0 || obs_vec() !== exp_vec())
      $display("FAIL wrap_second cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    step('0, '0, 1'b1);
    step(4'b0100, 16'h0A00, 1'b0);
    n_checks++;
    if (bif.bus_valid !== 1'b1 || bif.bus_data !== 4'hA || bif.bus_tag !== 2'd2)
      $display("FAIL pulse_bus cyc=%0d got v=%b data=%h tag=%0d exp v=1 data=a tag=2",
               cyc, bif.bus_valid, bif.bus_data, bif.bus_tag);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      step('0, 16'h0A00, 1'b0);
      n_checks++;
      if (k == 2 && (bif.out_valid !== 1'b1 || bif.out_tag !== 2'd2))
        $display("FAIL pulse_out cyc=%0d got v=%b tag=%0d exp v=1 tag=2", cyc, bif.out_valid, bif.out_tag);
      else if (k == 3 && bif.out_valid !== 1'b0)
        $display("FAIL pulse_out_end cyc=%0d got v=%b exp v=0", cyc, bif.out_valid);
      else if (obs_vec() !== exp_vec())
        $display("FAIL pulse_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 3; i++) step(4'b1111, 16'h9876, 1'b0);
    step(4'b1111, 16'h9876, 1'b1);
    n_checks++;
    if (obs_vec() !== '0 || bif.dbg_ptr !== '0)
      $display("FAIL midburst_reset cyc=%0d got=%h ptr=%0d exp=0 ptr=0", cyc, obs_vec(), bif.dbg_ptr);
    else n_pass++;
    step(4'b1111, 16'h9876, 1'b0);
    n_checks++;
    if (bif.gnt !== 4'b0001 || bif.bus_tag !== 2'd0 || bif.bus_data !== 4'h6 || bif.out_valid !== 1'b0)
      $display("FAIL midburst_restart cyc=%0d got=%h exp gnt=0001 tag=0 data=6 outv=0", cyc, obs_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0]  r;
    logic [DW-1:0] d;
    logic          rst;
    step('0, '0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) r = '0;
      d = DW'($urandom());
      rst = ($urandom_range(0, 39) == 0);
`ifdef ARB_LOCK_EN
      lock_in = N'($urandom_range(0, (1 << N) - 1));
`endif
      step(r, d, rst);
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random cyc=%0d req=%b got=%h exp=%h", cyc, r, obs_vec(), exp_vec());
      else n_pass++;
    end
`ifdef ARB_LOCK_EN
    lock_in = '0;
`endif
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    lock_in = '0;
    step('0, '0, 1'b1);
    lock_in = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(4'b0011, 16'h00B7, 1'b0);
      n_checks++;
      if (bif.bus_tag !== TW'(exp_seq[i]) || bif.gnt !== (N'(1) << exp_seq[i]) || obs_vec() !== exp_vec())
        $display("FAIL lock_seq cyc=%0d step=%0d got tag=%0d gnt=%b exp tag=%0d", cyc, i,
                 bif.bus_tag, bif.gnt, exp_seq[i]);
      else n_pass++;
    end
    lock_in = '0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset       = 1'b1;
    bif.req     = '0;
    bif.data_in = '0;
`ifdef ARB_LOCK_EN
    bif.lock    = '0;
`endif
    model_reset();
    test_reset();
    test_all_req();
    test_wrap();
    test_single_pulse();
    test_reset_midburst();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
